// File: rtl/lc3_mem_pkg.sv
// Shared types and widths for the LC3 unified-memory arbiter.
package lc3_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] ERR_WORD_DEF = 16'hDEAD;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/lc3_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module lc3_sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != W'(MAX)))
      count <= count + W'(1);
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates the LC3 fetch and data ports onto one single-port memory and
// sequences the req/ready handshake with a timeout abort.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned       STARVE_LIMIT = 4,
  parameter int unsigned       TIMEOUT      = 16,
  parameter logic [DATA_W-1:0] ERR_WORD     = ERR_WORD_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_macc,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              D_macc,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = 5;

  state_t            state, state_d;
  owner_t            owner, owner_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_req_d, mem_we_d, ci_d, cd_d, err_d;
  logic [DATA_W-1:0] instr_d, data_d;
  logic [SW-1:0]     starve_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              ireq, dreq, in_idle, grant_i, grant_d;

  assign ireq    = I_macc & instrmem_rd;
  assign dreq    = D_macc;
  assign in_idle = (state == IDLE);
  // Data has priority until the waiting fetch has been passed over STARVE_LIMIT times.
  assign grant_i = in_idle & ireq & (~dreq | (starve_cnt == SW'(STARVE_LIMIT)));
  assign grant_d = in_idle & dreq & ~grant_i;

  lc3_sat_counter #(.W(SW), .MAX(STARVE_LIMIT)) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (grant_i | (in_idle & ~ireq)),
    .inc   (grant_d & ireq),
    .count (starve_cnt)
  );

  lc3_sat_counter #(.W(TW), .MAX((1 << TW) - 1)) u_tmo_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (in_idle),
    .inc   (state == ACCESS),
    .count (tmo_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= OWN_I;
      cmd_q          <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      state          <= state_d;
      owner          <= owner_d;
      cmd_q          <= cmd_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      Instr_dout     <= instr_d;
      Data_dout      <= data_d;
      complete_instr <= ci_d;
      complete_data  <= cd_d;
      mem_err        <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    owner_d   = owner;
    cmd_d     = cmd_q;
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    instr_d   = Instr_dout;
    data_d    = Data_dout;
    ci_d      = 1'b0;
    cd_d      = 1'b0;
    err_d     = mem_err;
    case (state)
      IDLE: begin
        if (grant_i || grant_d) begin
          state_d   = ACCESS;
          owner_d   = grant_d ? OWN_D : OWN_I;
          cmd_d     = '{addr: (grant_d ? Data_addr : pc), wdata: Data_din};
          mem_req_d = 1'b1;
          mem_we_d  = grant_d & ~Data_rd;
        end
      end
      ACCESS: begin
        mem_req_d = 1'b1;
        mem_we_d  = mem_we;
        if (mem_ready || (tmo_cnt == TW'(TIMEOUT - 1))) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ci_d      = (owner == OWN_I);
          cd_d      = (owner == OWN_D);
          err_d     = mem_err | ~mem_ready;
          // Reads return memory data, or the error word on an abort.
          if (!mem_we) begin
            if (owner == OWN_D)
              data_d = mem_ready ? mem_rdata : ERR_WORD;
            else
              instr_d = mem_ready ? mem_rdata : ERR_WORD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed self-checking bench for lc3_mem_arbiter.
module tb_lc3_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_macc, instrmem_rd, D_macc, Data_rd, mem_ready;
  logic [15:0] pc, Data_addr, Data_din, mem_rdata;
  logic [15:0] Instr_dout, Data_dout, mem_addr, mem_wdata;
  logic        complete_instr, complete_data, mem_req, mem_we, mem_err;

  int passed = 0;
  int total  = 0;
  int both_hi = 0;

  lc3_mem_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .I_macc         (I_macc),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .Instr_dout     (Instr_dout),
    .complete_instr (complete_instr),
    .D_macc         (D_macc),
    .Data_rd        (Data_rd),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .Data_dout      (Data_dout),
    .complete_data  (complete_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .mem_err        (mem_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (complete_instr && complete_data) both_hi++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          nrec;
    logic [9:0]  got;

    reset = 1'b1; I_macc = 0; instrmem_rd = 0; D_macc = 0; Data_rd = 0;
    mem_ready = 0; pc = 0; Data_addr = 0; Data_din = 0; mem_rdata = 0;
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_complete", 32'({complete_instr, complete_data}), 32'd0);
    chk("rst_dout", 32'({Instr_dout, Data_dout}), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // single fetch, zero wait states
    I_macc = 1; instrmem_rd = 1; pc = 16'h3000;
    tick();
    chk("f1_req", 32'(mem_req), 32'd1);
    chk("f1_addr", 32'(mem_addr), 32'h3000);
    chk("f1_we", 32'(mem_we), 32'd0);
    chk("f1_cmp_early", 32'(complete_instr), 32'd0);
    mem_ready = 1; mem_rdata = 16'h1021;
    tick();
    chk("f1_complete", 32'(complete_instr), 32'd1);
    chk("f1_instr", 32'(Instr_dout), 32'h1021);
    chk("f1_req_off", 32'(mem_req), 32'd0);
    I_macc = 0; instrmem_rd = 0; mem_ready = 0;
    tick();
    chk("f1_pulse_end", 32'(complete_instr), 32'd0);
    tick();
    chk("f1_idle", 32'(mem_req), 32'd0);

    // data write with two wait states
    D_macc = 1; Data_rd = 0; Data_addr = 16'h4000; Data_din = 16'hBEEF;
    tick();
    chk("w_req", 32'(mem_req), 32'd1);
    chk("w_we", 32'(mem_we), 32'd1);
    chk("w_addr", 32'(mem_addr), 32'h4000);
    chk("w_wdata", 32'(mem_wdata), 32'hBEEF);
    tick(); tick();
    chk("w_wait_req", 32'(mem_req), 32'd1);
    chk("w_wait_cmp", 32'(complete_data), 32'd0);
    chk("w_wait_wdata", 32'(mem_wdata), 32'hBEEF);
    mem_ready = 1;
    tick();
    chk("w_complete", 32'(complete_data), 32'd1);
    chk("w_dout_kept", 32'(Data_dout), 32'h0000);
    chk("w_no_instr", 32'(complete_instr), 32'd0);
    D_macc = 0; mem_ready = 0;
    tick();
    chk("w_pulse_end", 32'(complete_data), 32'd0);

    // both requests held: starvation guard
    I_macc = 1; instrmem_rd = 1; pc = 16'h3100;
    D_macc = 1; Data_rd = 1; Data_addr = 16'h5000;
    mem_ready = 1; mem_rdata = 16'h5A5A;
    nrec = 0; got = '0;
    for (int c = 0; c < 60 && nrec < 10; c++) begin
      tick();
      if (complete_data) begin got = {got[8:0], 1'b0}; nrec++; end
      else if (complete_instr) begin got = {got[8:0], 1'b1}; nrec++; end
    end
    chk("st_count", 32'(nrec), 32'd10);
    chk("st_order", 32'(got), 32'(10'b0000100001));
    chk("st_dout", 32'({Instr_dout, Data_dout}), 32'h5A5A5A5A);
    I_macc = 0; instrmem_rd = 0; D_macc = 0; mem_ready = 0;
    tick(); tick();
    chk("st_both_hi", 32'(both_hi), 32'd0);

    // data read that never gets mem_ready
    D_macc = 1; Data_rd = 1; Data_addr = 16'h1234;
    tick();
    chk("to_req", 32'(mem_req), 32'd1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n++;
      if (complete_data) break;
    end
    chk("to_latency", 32'(n), 32'd16);
    chk("to_complete", 32'(complete_data), 32'd1);
    chk("to_dout", 32'(Data_dout), 32'hDEAD);
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_req_off", 32'(mem_req), 32'd0);
    D_macc = 0;
    tick(); tick();
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    // asynchronous reset in the middle of an access
    I_macc = 1; instrmem_rd = 1; pc = 16'h0042;
    tick();
    chk("ar_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req_drop", 32'(mem_req), 32'd0);
    chk("ar_err_clr", 32'(mem_err), 32'd0);
    mem_ready = 1; mem_rdata = 16'h9999;
    tick();
    chk("ar_no_cmp", 32'({complete_instr, complete_data}), 32'd0);
    reset = 1'b0; mem_ready = 0;
    tick();
    chk("ar_regrant", 32'(mem_req), 32'd1);
    chk("ar_addr", 32'(mem_addr), 32'h0042);
    mem_ready = 1; mem_rdata = 16'hABCD;
    tick();
    chk("ar_complete", 32'(complete_instr), 32'd1);
    chk("ar_instr", 32'(Instr_dout), 32'hABCD);
    I_macc = 0; instrmem_rd = 0; mem_ready = 0;
    tick();

    // fetch request dropped while the access is in flight
    I_macc = 1; instrmem_rd = 1; pc = 16'h3001;
    tick();
    chk("dr_req", 32'(mem_req), 32'd1);
    I_macc = 0; instrmem_rd = 0;
    tick();
    chk("dr_req_held", 32'(mem_req), 32'd1);
    chk("dr_addr_held", 32'(mem_addr), 32'h3001);
    mem_ready = 1; mem_rdata = 16'h7777;
    tick();
    chk("dr_complete", 32'(complete_instr), 32'd1);
    chk("dr_instr", 32'(Instr_dout), 32'h7777);
    mem_ready = 0;
    tick();
    chk("dr_pulse_end", 32'(complete_instr), 32'd0);
    tick(); tick();
    chk("dr_idle", 32'({mem_req, complete_instr, complete_data}), 32'd0);
    chk("dr_both_hi", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
